// File: rtl/nlb_mem_responder.sv
// rtl/nlb_mem_responder.sv - NLB far-side responder: in-order read bursts, packed/unpacked write acks
// Flow control, fixed-latency responses, address-derived read data, sticky protocol error.
module nlb_mem_responder #(
  parameter int ADDR_LMT      = 20,
  parameter int RD_DEPTH      = 8,
  parameter int WR_DEPTH      = 16,
  parameter int WR_ALM_THRESH = 4,
  parameter int RSP_LAT       = 4,
  parameter int PACK_WR       = 1
) (
  input  logic                Clk_400,
  input  logic                test_Reset,
  input  logic                rw2ab_RdEn,
  input  logic [ADDR_LMT-1:0] rw2ab_RdAddr,
  input  logic [15:0]         rw2ab_RdTID,
  input  logic [1:0]          rw2ab_RdLen,
  input  logic                rw2ab_RdSop,
  output logic                ab2rw_RdSent,
  input  logic                rw2ab_WrEn,
  input  logic [ADDR_LMT-1:0] rw2ab_WrAddr,
  input  logic [15:0]         rw2ab_WrTID,
  input  logic [511:0]        rw2ab_WrDin,
  input  logic [1:0]          rw2ab_WrLen,
  input  logic                rw2ab_WrSop,
  output logic                ab2rw_WrSent,
  output logic                ab2rw_WrAlmFull,
  output logic                ab2rw_RdRspValid,
  output logic [15:0]         ab2rw_RdRsp,
  output logic [ADDR_LMT-1:0] ab2rw_RdRspAddr,
  output logic [511:0]        ab2rw_RdData,
  output logic                ab2rw_RdRspFormat,
  output logic [1:0]          ab2rw_RdRspCLnum,
  output logic                ab2rw_WrRspValid,
  output logic [15:0]         ab2rw_WrRsp,
  output logic [ADDR_LMT-1:0] ab2rw_WrRspAddr,
  output logic                ab2rw_WrRspFormat,
  output logic [1:0]          ab2rw_WrRspCLnum,
  output logic                proto_err
);

  localparam int RD_AW = $clog2(RD_DEPTH);
  localparam int WR_AW = $clog2(WR_DEPTH);
  localparam int WR_CW = WR_AW + 1;
  localparam logic [15:0] LAT = 16'(RSP_LAT);
  localparam logic [WR_CW-1:0] WR_FULL = WR_CW'(WR_DEPTH);
  localparam logic [WR_CW-1:0] ALM_LVL = WR_CW'(WR_DEPTH - WR_ALM_THRESH);
  localparam bit PACK = (PACK_WR != 0);

  logic [15:0] now;

  logic wr_din_unused;
  assign wr_din_unused = ^rw2ab_WrDin;

  // ---------------- read path ----------------
  logic [15:0]         rdq_stamp [RD_DEPTH];
  logic [ADDR_LMT-1:0] rdq_addr  [RD_DEPTH];
  logic [15:0]         rdq_tid   [RD_DEPTH];
  logic [1:0]          rdq_len   [RD_DEPTH];
  logic [RD_AW:0]      rd_wp, rd_rp;
  logic [RD_AW-1:0]    rd_head;
  logic [1:0]          rd_beat;
  logic [15:0]         rd_age;
  logic [ADDR_LMT-1:0] rd_addr;
  logic [31:0]         rd_a32;
  logic                rdq_empty, rdq_full, rd_push, rd_fire, rd_pop, rd_perr;

  assign rdq_empty = (rd_wp == rd_rp);
  assign rdq_full  = (rd_wp[RD_AW] != rd_rp[RD_AW]) &&
                     (rd_wp[RD_AW-1:0] == rd_rp[RD_AW-1:0]);
  assign ab2rw_RdSent = rw2ab_RdEn & ~rdq_full & ~test_Reset;
  assign rd_push = ab2rw_RdSent;
  assign rd_perr = rd_push & ~rw2ab_RdSop;

  assign rd_head = rd_rp[RD_AW-1:0];
  // Modular difference keeps the age correct across counter wrap.
  assign rd_age  = now - rdq_stamp[rd_head];
  assign rd_fire = ~rdq_empty && (rd_age >= LAT);
  assign rd_pop  = rd_fire && (rd_beat == rdq_len[rd_head]);
  assign rd_addr = rdq_addr[rd_head] + ADDR_LMT'(rd_beat);
  assign rd_a32  = 32'(rd_addr);

  assign ab2rw_RdRspValid  = rd_fire;
  assign ab2rw_RdRsp       = rd_fire ? rdq_tid[rd_head] : 16'd0;
  assign ab2rw_RdRspAddr   = rd_fire ? rd_addr : '0;
  assign ab2rw_RdData      = rd_fire ? {448'd0, ~rd_a32, rd_a32} : 512'd0;
  assign ab2rw_RdRspFormat = 1'b0;
  assign ab2rw_RdRspCLnum  = rd_fire ? rd_beat : 2'd0;

  always_ff @(posedge Clk_400) begin
    if (rd_push) begin
      rdq_stamp[rd_wp[RD_AW-1:0]] <= now;
      rdq_addr[rd_wp[RD_AW-1:0]]  <= rw2ab_RdAddr;
      rdq_tid[rd_wp[RD_AW-1:0]]   <= rw2ab_RdTID;
      rdq_len[rd_wp[RD_AW-1:0]]   <= rw2ab_RdLen;
    end
  end

  // ---------------- write path ----------------
  logic [15:0]         wrq_stamp [WR_DEPTH];
  logic [15:0]         wrq_tid   [WR_DEPTH];
  logic [ADDR_LMT-1:0] wrq_addr  [WR_DEPTH];
  logic                wrq_fmt   [WR_DEPTH];
  logic [1:0]          wrq_cl    [WR_DEPTH];
  logic [WR_AW-1:0]    wr_wp, wr_rp;
  logic [WR_CW-1:0]    wr_cnt, wr_cnt_next;
  logic [15:0]         wr_age;
  logic                wrq_full, wr_fire;

  logic                wr_open, open_next;
  logic [1:0]          wr_rem, rem_next, wr_len;
  logic [ADDR_LMT-1:0] wr_base;
  logic [15:0]         wr_tid;
  logic                wr_push, wr_perr, push_fmt;
  logic [15:0]         push_tid;
  logic [ADDR_LMT-1:0] push_addr;
  logic [1:0]          push_cl;

  assign wrq_full = (wr_cnt == WR_FULL);
  assign ab2rw_WrSent = rw2ab_WrEn & ~wrq_full & ~test_Reset;

  assign wr_age  = now - wrq_stamp[wr_rp];
  assign wr_fire = (wr_cnt != '0) && (wr_age >= LAT);

  assign ab2rw_WrRspValid  = wr_fire;
  assign ab2rw_WrRsp       = wr_fire ? wrq_tid[wr_rp] : 16'd0;
  assign ab2rw_WrRspAddr   = wr_fire ? wrq_addr[wr_rp] : '0;
  assign ab2rw_WrRspFormat = wr_fire & wrq_fmt[wr_rp];
  assign ab2rw_WrRspCLnum  = wr_fire ? wrq_cl[wr_rp] : 2'd0;

  // Packet tracker: decides what (if anything) each accepted beat enqueues.
  always_comb begin
    wr_push   = 1'b0;
    wr_perr   = 1'b0;
    push_tid  = rw2ab_WrTID;
    push_addr = rw2ab_WrAddr;
    push_fmt  = 1'b0;
    push_cl   = 2'd0;
    open_next = wr_open;
    rem_next  = wr_rem;
    if (ab2rw_WrSent) begin
      if (rw2ab_WrSop) begin
        wr_perr   = wr_open;
        open_next = (rw2ab_WrLen != 2'd0);
        rem_next  = rw2ab_WrLen;
        wr_push   = ~PACK || (rw2ab_WrLen == 2'd0);
      end else if (!wr_open) begin
        wr_perr = 1'b1;
        wr_push = 1'b1;
      end else begin
        rem_next = wr_rem - 2'd1;
        if (wr_rem == 2'd1) begin
          open_next = 1'b0;
          wr_push   = 1'b1;
          if (PACK) begin
            push_tid  = wr_tid;
            push_addr = wr_base;
            push_fmt  = 1'b1;
            push_cl   = wr_len;
          end
        end else begin
          wr_push = ~PACK;
        end
      end
    end
  end

  always_comb begin
    wr_cnt_next = wr_cnt;
    case ({wr_push, wr_fire})
      2'b10:   wr_cnt_next = wr_cnt + WR_CW'(1);
      2'b01:   wr_cnt_next = wr_cnt - WR_CW'(1);
      default: wr_cnt_next = wr_cnt;
    endcase
  end

  always_ff @(posedge Clk_400) begin
    if (wr_push) begin
      wrq_stamp[wr_wp] <= now;
      wrq_tid[wr_wp]   <= push_tid;
      wrq_addr[wr_wp]  <= push_addr;
      wrq_fmt[wr_wp]   <= push_fmt;
      wrq_cl[wr_wp]    <= push_cl;
    end
    if (ab2rw_WrSent && rw2ab_WrSop) begin
      wr_base <= rw2ab_WrAddr;
      wr_tid  <= rw2ab_WrTID;
      wr_len  <= rw2ab_WrLen;
    end
  end

  // ---------------- control state ----------------
  always_ff @(posedge Clk_400) begin
    if (test_Reset) begin
      now             <= 16'd0;
      rd_wp           <= '0;
      rd_rp           <= '0;
      rd_beat         <= 2'd0;
      wr_wp           <= '0;
      wr_rp           <= '0;
      wr_cnt          <= '0;
      wr_open         <= 1'b0;
      wr_rem          <= 2'd0;
      ab2rw_WrAlmFull <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      now <= now + 16'd1;
      if (rd_push) rd_wp <= rd_wp + {{RD_AW{1'b0}}, 1'b1};
      if (rd_pop) begin
        rd_rp   <= rd_rp + {{RD_AW{1'b0}}, 1'b1};
        rd_beat <= 2'd0;
      end else if (rd_fire) begin
        rd_beat <= rd_beat + 2'd1;
      end
      if (wr_push) wr_wp <= wr_wp + {{(WR_AW-1){1'b0}}, 1'b1};
      if (wr_fire) wr_rp <= wr_rp + {{(WR_AW-1){1'b0}}, 1'b1};
      wr_cnt          <= wr_cnt_next;
      wr_open         <= open_next;
      wr_rem          <= rem_next;
      ab2rw_WrAlmFull <= (wr_cnt_next >= ALM_LVL);
      if (rd_perr || wr_perr) proto_err <= 1'b1;
    end
  end

endmodule
